// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package rf_wb_pkg;

    localparam int unsigned RF_ADDR_W   = 4;
    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_NUM_REGS = 1 << RF_ADDR_W;

    // One buffered writeback: destination register and the value to write.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of writeback entries. Exposes every slot plus a per-slot valid
// bit so the parent can scan in-flight writes for the pending mask and bypass.
module wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  wb_entry_t                     push_entry_i,
    input  logic                          pop_i,
    output wb_entry_t                     head_o,
    output wb_entry_t [DEPTH-1:0]         entries_o,
    output logic [DEPTH-1:0]              valid_o,
    output logic [$clog2(DEPTH)-1:0]      rd_ptr_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [PtrW-1:0]       offs [DEPTH];

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end

    // State registers; reset discards every buffered entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_entry_i;
            end
        end
    end

    // A slot is valid when its distance from the head is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            offs[i]    = PtrW'(i) - rd_ptr_q;
            valid_o[i] = {1'b0, offs[i]} < count_q;
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign count_o   = count_q;

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-side companion to the 16x32 register file: arbitrates ALU/load
// writebacks into an in-order FIFO, drains one per cycle onto the write port
// and exports a pending mask of registers with writes in flight.
// Optional: define WB_BYPASS_EN to add two forwarding lookup ports.
module reg_writeback_unit
    import rf_wb_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     hold,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_addr,
    output logic [DATA_W-1:0]        rf_data,
    output logic [(1<<ADDR_W)-1:0]   pending,
    output logic [$clog2(DEPTH):0]   count
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]        byp_addr1,
    input  logic [ADDR_W-1:0]        byp_addr2,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic [DATA_W-1:0]        byp_data1,
    output logic [DATA_W-1:0]        byp_data2
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic                  pop;
    logic                  push;
    logic                  full_eff;
    wb_entry_t             push_entry;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic [PtrW-1:0]       rd_ptr;
    logic [CntW-1:0]       fifo_count;

    // Drain control and source arbitration; a same-cycle pop frees a slot,
    // and the load path wins because it belongs to the older instruction.
    always_comb begin
        pop        = (fifo_count != '0) && !hold;
        full_eff   = (fifo_count == CntW'(DEPTH)) && !pop;
        mem_ready  = !full_eff;
        alu_ready  = !full_eff && !mem_valid;
        push       = (mem_valid && mem_ready) || (alu_valid && alu_ready);
        push_entry = '0;
        if (mem_valid) begin
            push_entry.addr = mem_addr;
            push_entry.data = mem_data;
        end else begin
            push_entry.addr = alu_addr;
            push_entry.data = alu_data;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clock),
        .rst_ni       (reset_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .entries_o    (entries),
        .valid_o      (valid),
        .rd_ptr_o     (rd_ptr),
        .count_o      (fifo_count)
    );

    // Register file write port: address/data forced to zero when idle.
    always_comb begin
        rf_we   = pop;
        rf_addr = '0;
        rf_data = '0;
        if (pop) begin
            rf_addr = head.addr;
            rf_data = head.data;
        end
    end

    // Pending mask covers every valid entry, including the head being written now.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                pending[entries[i].addr] = 1'b1;
            end
        end
    end

    assign count = fifo_count;

`ifdef WB_BYPASS_EN
    logic [PtrW-1:0] age_idx [DEPTH];

    // Scan oldest to youngest so the youngest matching entry supplies the data.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            age_idx[k] = rd_ptr + PtrW'(k);
            if (valid[age_idx[k]] && (entries[age_idx[k]].addr == byp_addr1)) begin
                byp_hit1  = 1'b1;
                byp_data1 = entries[age_idx[k]].data;
            end
            if (valid[age_idx[k]] && (entries[age_idx[k]].addr == byp_addr2)) begin
                byp_hit2  = 1'b1;
                byp_data2 = entries[age_idx[k]].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_reg_writeback_unit;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid, alu_ready, mem_valid, mem_ready, hold;
    logic [3:0]  alu_addr, mem_addr, rf_addr;
    logic [31:0] alu_data, mem_data, rf_data;
    logic        rf_we;
    logic [15:0] pending;
    logic [2:0]  count;
`ifdef WB_BYPASS_EN
    logic [3:0]  byp_addr1, byp_addr2;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;
`endif

    always #5 clock = ~clock;

    reg_writeback_unit dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .hold      (hold),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .pending   (pending),
        .count     (count)
`ifdef WB_BYPASS_EN
        ,
        .byp_addr1 (byp_addr1),
        .byp_addr2 (byp_addr2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2)
`endif
    );

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check just after, update model at posedge.
    task automatic cycle(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [3:0] ma, input logic [31:0] md,
                         input logic hd);
        logic        pop_e, full_e, mr_e, ar_e;
        logic [15:0] pend_e;
        logic [3:0]  addr_e;
        logic [31:0] data_e;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        hold = hd;
        #1;
        pop_e  = (q.size() != 0) && !hd;
        full_e = (q.size() == DEPTH) && !pop_e;
        mr_e   = !full_e;
        ar_e   = !full_e && !mv;
        pend_e = '0;
        foreach (q[i]) pend_e[q[i].a] = 1'b1;
        addr_e = '0;
        data_e = '0;
        if (pop_e) begin
            addr_e = q[0].a;
            data_e = q[0].d;
        end
        chk("count", 64'(count), 64'(q.size()));
        chk("rf_we", 64'(rf_we), 64'(pop_e));
        chk("rf_addr", 64'(rf_addr), 64'(addr_e));
        chk("rf_data", 64'(rf_data), 64'(data_e));
        chk("mem_ready", 64'(mem_ready), 64'(mr_e));
        chk("alu_ready", 64'(alu_ready), 64'(ar_e));
        chk("pending", 64'(pending), 64'(pend_e));
`ifdef WB_BYPASS_EN
        begin
            logic        h1, h2;
            logic [31:0] d1, d2;
            h1 = 0; h2 = 0; d1 = 0; d2 = 0;
            foreach (q[i]) begin
                if (q[i].a == byp_addr1) begin h1 = 1; d1 = q[i].d; end
                if (q[i].a == byp_addr2) begin h2 = 1; d2 = q[i].d; end
            end
            chk("byp_hit1", 64'(byp_hit1), 64'(h1));
            chk("byp_data1", 64'(byp_data1), 64'(d1));
            chk("byp_hit2", 64'(byp_hit2), 64'(h2));
            chk("byp_data2", 64'(byp_data2), 64'(d2));
        end
`endif
        @(posedge clock);
        if (pop_e) void'(q.pop_front());
        if (mv && mr_e) q.push_back('{ma, md});
        else if (av && ar_e) q.push_back('{aa, ad});
        @(negedge clock);
    endtask

    task automatic idle(input logic hd);
        cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, hd);
    endtask

    initial begin
        reset_n = 1'b0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        hold = 0;
`ifdef WB_BYPASS_EN
        byp_addr1 = 4'd3; byp_addr2 = 4'd4;
`endif
        // Reset state
        @(negedge clock); #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_addr", 64'(rf_addr), 64'd0);
        chk("rst_rf_data", 64'(rf_data), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // 1: single ALU write, visible one cycle later
        cycle(1'b1, 4'd4, 32'h2, 1'b0, 4'd0, 32'h0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // 2: both sources valid, load goes first
        cycle(1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB, 1'b0);
        cycle(1'b1, 4'd1, 32'hA, 1'b0, 4'd0, 32'h0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // 3: fill while holding, then blocked requests
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 8), 32'h100 + i, 1'b0, 4'd0, 32'h0, 1'b1);
        cycle(1'b1, 4'd5, 32'h55, 1'b1, 4'd6, 32'h66, 1'b1);
        // 4: full, hold released, load pushes while head drains
        cycle(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h77, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // 5: two writes to r3 in flight
        cycle(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'h0, 1'b1);
        cycle(1'b1, 4'd3, 32'h22, 1'b0, 4'd0, 32'h0, 1'b1);
        idle(1'b1);
        for (int i = 0; i < 3; i++) idle(1'b0);

        // 6: asynchronous reset with three entries buffered
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 1), 32'h300 + i, 1'b0, 4'd0, 32'h0, 1'b1);
        alu_valid = 0; mem_valid = 0; hold = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_rf_we", 64'(rf_we), 64'd0);
        chk("arst_pending", 64'(pending), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) idle(1'b0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
`ifdef WB_BYPASS_EN
            byp_addr1 = 4'($urandom_range(0, 15));
            byp_addr2 = 4'($urandom_range(0, 15));
`endif
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
